// File: rtl/lfsr_1.sv
// lfsr_1: seeded 16-bit Fibonacci LFSR; loads seed on the first edge after reset, then shifts every cycle.
// A zero seed is replaced by ZERO_SUB so the register can never lock up in the all-zero state.
module lfsr_1 #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0]   ZERO_SUB = 16'h0001
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr_out
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             loaded_q;

    // Feedback bit is shifted into the LSB; the load edge takes seed instead of shifting.
    always_comb q_d = loaded_q ? {q_q[WIDTH-2:0], ^(q_q & TAPS)}
                               : ((seed == '0) ? ZERO_SUB : seed);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q      <= '0;
            loaded_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            loaded_q <= 1'b1;
        end
    end

    assign lfsr_out = q_q;
endmodule

// File: tb/tb_lfsr_1.sv
// tb_lfsr_1: scoreboard bench; stimulus queues expected states, a monitor compares one per clock edge.
module tb_lfsr_1;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] seed = 16'h0001;
    logic [15:0] lfsr_out;
    logic [15:0] exp_q[$];
    logic [15:0] ref1[17] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020,
                              16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801,
                              16'h1002, 16'h2005, 16'h400B, 16'h8016, 16'h002D};
    int errors = 0;
    int checks = 0;

    lfsr_1 dut (.clk(clk), .resetn(resetn), .seed(seed), .lfsr_out(lfsr_out));

    always #5 clk = ~clk;

    function automatic logic [15:0] model_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Monitor: one expected state per rising edge while the scoreboard holds entries.
    initial forever begin
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            checks++;
            if (lfsr_out !== e) begin
                errors++;
                $display("FAIL seq check %0d: got %h expected %h", checks, lfsr_out, e);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain timeout: %0d entries left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_and_load(input logic [15:0] s);
        @(negedge clk);
        resetn = 1'b0;
        seed   = s;
        #1 check("reset_zero", lfsr_out, 16'h0000);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic push_ref1();
        for (int i = 0; i < 17; i++) exp_q.push_back(ref1[i]);
    endtask

    initial begin
        logic [15:0] m;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", lfsr_out, 16'h0000);
        // Seed 1: hand-computed prefix then 256 model steps
        @(negedge clk);
        resetn = 1'b1;
        push_ref1();
        m = 16'h002D;
        for (int i = 0; i < 256; i++) begin
            m = model_next(m);
            exp_q.push_back(m);
        end
        drain(400);
        // Zero seed falls back to 0001 and follows the same sequence
        reset_and_load(16'h0000);
        push_ref1();
        drain(40);
        // Seed changes after the load edge must be ignored
        reset_and_load(16'h0001);
        push_ref1();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            seed = 16'(($urandom & 16'hFFFF) | 16'h8000);
        end
        drain(40);
        // Mid-run asynchronous reset, then reload with a new seed
        reset_and_load(16'h0001);
        m = 16'h0001;
        exp_q.push_back(m);
        for (int i = 0; i < 50; i++) begin
            m = model_next(m);
            exp_q.push_back(m);
        end
        drain(100);
        #1 resetn = 1'b0;
        #1 check("async_reset", lfsr_out, 16'h0000);
        seed = 16'h0002;
        @(negedge clk);
        check("reset_held", lfsr_out, 16'h0000);
        resetn = 1'b1;
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0008);
        drain(20);
        // Full period from ACE1: returns to ACE1 exactly 65535 steps after load
        reset_and_load(16'hACE1);
        m = 16'hACE1;
        exp_q.push_back(m);
        for (int i = 1; i < 65535; i++) begin
            m = model_next(m);
            exp_q.push_back(m);
        end
        exp_q.push_back(16'hACE1);
        drain(66000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lfsr_1.md
Name: lfsr_1

Overview:
- 16-bit seeded maximal-length Fibonacci LFSR used as a pseudo-random source for the F_node neural-network datapath and its test benches.
- Loads a caller-supplied seed on the first clock edge after reset release, then advances one step per clock.
- Output is fully registered; the output sequence must match the golden software model bit-exactly, cycle by cycle.

Parameters:
- WIDTH, 16, register and seed width; only 16 is required to be verified.
- TAPS, 16'hB400, feedback mask (bits 15,13,12,10 = x^16+x^14+x^13+x^11+1).
- ZERO_SUB, 16'h0001, value substituted when the seed is all-zero (lock-up guard).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- resetn  input  1  asynchronous, active-low reset.
- seed  input  WIDTH  initial state; sampled only on the load edge.
- lfsr_out  output  WIDTH  current LFSR state, driven directly from the state register.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (resetn).
- Internal state: the state register q[15:0] and a 1-bit flag "loaded".
- resetn=0: immediately forces q=16'h0000, loaded=0, lfsr_out=16'h0000. Holds while resetn is low, regardless of clk.
- First rising edge with resetn=1 and loaded=0 (load edge):
  - q <= seed, or ZERO_SUB if seed==0.
  - loaded <= 1.
  - No shift occurs on this edge.
- Every later rising edge with loaded=1:
  - fb = q[15]^q[13]^q[12]^q[10], i.e. XOR-reduce of (q & TAPS).
  - q <= {q[14:0], fb}.
- seed is ignored after the load edge. Changing seed mid-run has no effect until the next reset.
- Latency: lfsr_out = seed immediately after the load edge; each later edge produces the next sequence value.
- Period: 65535 states for any nonzero seed. The all-zero state is unreachable once loaded.
- Reset asserted mid-sequence:
  - Output clears asynchronously to 0.
  - After release, the next edge reloads seed (the sampled value at that edge).
- Reset released coincident with a clock edge: that edge is not a load edge; the load happens on the following edge.
- No enable, no handshake; the register advances unconditionally every cycle once loaded.
- All state updates are synchronous to the rising edge of clk except reset.

Test Plan:
- Reset/seed load: resetn=0 with seed=16'h0001 -> lfsr_out=0 during reset. Release resetn at a negedge; after the first posedge lfsr_out=16'h0001.
- Sequence check, seed=1, values after the load edge k=0..16:
  - k=0..10: 0001, 0002, 0004, 0008, 0010, 0020, 0040, 0080, 0100, 0200, 0400.
  - k=11..16: 0801, 1002, 2005, 400B, 8016, 002D.
  - Then run 256 cycles against the software model with zero mismatches.
- Zero seed: seed=16'h0000 -> after the load edge lfsr_out=16'h0001, then an identical sequence to seed=1.
- Period: seed=16'hACE1 -> returns to 16'hACE1 exactly 65535 cycles after the load edge, and never equals 0.
- Mid-run reset:
  - After 50 cycles, pulse resetn low asynchronously (between edges) -> lfsr_out=0 immediately.
  - Change seed to 16'h0002 before release -> after release and the next edge, lfsr_out=16'h0002, followed by 0004, 0008.
- Seed stability: toggle seed every cycle after the load edge -> sequence is unaffected (matches the seed=1 reference values above).
